// File: rtl/ble4_lut4_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ble_cfg_pkg
// Description : Shared types and constants for the BLE4 configurable LUT.
// Revision    : 1.0 - initial release
// ============================================================================
package ble_cfg_pkg;

    localparam int   c_LUT_SIZE_DEF = 4;
    localparam int   c_CNT_W        = 5;
    localparam logic c_PAR_ODD      = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ACTIVE = 2'd2
    } cfg_state_e;

    // Chain length: full truth table plus one parity bit.
    function automatic int frame_w(input int lut_size);
        return (2 ** lut_size) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ble4_lut4_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : ble4_lut4_cfg_if
// Description : Configuration-chain and LUT datapath bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ble4_lut4_cfg_if
    import ble_cfg_pkg::*;
#(
    parameter int LUT_SIZE = c_LUT_SIZE_DEF
);
    logic                cfg_en;
    logic                ccff_head;
    logic                ccff_tail;
    logic [LUT_SIZE-1:0] lut_in;
    logic                lut_out;
    logic                cfg_valid;
    logic                cfg_err;

    modport master (
        output cfg_en, ccff_head, lut_in,
        input  ccff_tail, lut_out, cfg_valid, cfg_err
    );

    modport slave (
        input  cfg_en, ccff_head, lut_in,
        output ccff_tail, lut_out, cfg_valid, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/ble4_lut4_cfg_chain.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_chain
// Description : Serial config shift register, saturating bit counter, parity.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_cfg_chain
    import ble_cfg_pkg::*;
#(
    parameter int FRAME_W = frame_w(c_LUT_SIZE_DEF)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               shift_i,
    input  wire logic               start_i,
    input  wire logic               head_i,
    output logic [FRAME_W-1:0]      sr_o,
    output logic [c_CNT_W-1:0]      cnt_o,
    output logic                    par_ok_o
);
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (shift_i) begin
            sr_d = {sr_q[FRAME_W-2:0], head_i};
            // First bit of a frame restarts the count; otherwise saturate.
            if (start_i)
                cnt_d = c_CNT_W'(1);
            else if (cnt_q != {c_CNT_W{1'b1}})
                cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_o     = sr_q;
    assign cnt_o    = cnt_q;
    assign par_ok_o = ((^sr_q) == c_PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/ble4_lut4_cfg.sv
`default_nettype none
// ============================================================================
// Module      : ble4_lut4_cfg
// Description : Chain-programmed 4-input LUT with atomic, parity-checked commit.
// Revision    : 1.0 - initial release
// ============================================================================
module ble4_lut4_cfg
    import ble_cfg_pkg::*;
#(
    parameter int LUT_SIZE = c_LUT_SIZE_DEF,
    parameter int FRAME_W  = frame_w(LUT_SIZE)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ble4_lut4_cfg_if.slave  bus
);
    localparam int                 c_TT_W      = 2 ** LUT_SIZE;
    localparam logic [c_CNT_W-1:0] c_FRAME_CNT = c_CNT_W'(FRAME_W);

    cfg_state_e          state_q, state_d;
    logic [c_TT_W-1:0]   mem_q, mem_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [FRAME_W-1:0]  w_sr;
    logic [c_CNT_W-1:0]  w_cnt;
    logic                w_par_ok;
    logic                w_start;

    assign w_start = (state_q != SHIFT);

    lut_cfg_chain #(
        .FRAME_W (FRAME_W)
    ) u_chain (
        .clk      (clk),
        .reset    (reset),
        .shift_i  (bus.cfg_en),
        .start_i  (w_start),
        .head_i   (bus.ccff_head),
        .sr_o     (w_sr),
        .cnt_o    (w_cnt),
        .par_ok_o (w_par_ok)
    );

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (bus.cfg_en) begin
                    state_d = SHIFT;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (!bus.cfg_en) begin
                    // Commit only a full-length, odd-parity frame; otherwise keep old table.
                    if ((w_cnt == c_FRAME_CNT) && w_par_ok) begin
                        mem_d   = w_sr[c_TT_W-1:0];
                        valid_d = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = valid_q ? ACTIVE : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mem_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Gate on cfg_en directly so the output drops in the same cycle shifting starts.
    assign bus.lut_out   = ((state_q == ACTIVE) && !bus.cfg_en) ? mem_q[bus.lut_in] : 1'b0;
    assign bus.ccff_tail = w_sr[FRAME_W-1];
    assign bus.cfg_valid = valid_q;
    assign bus.cfg_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ble4_lut4_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ble4_lut4_cfg
// Description : Directed-vector self-checking bench for ble4_lut4_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ble4_lut4_cfg;

    typedef struct {
        logic        do_shift;
        logic [17:0] frame;
        int          nbits;
        logic [3:0]  lin;
        logic        ev;
        logic        ee;
        logic        eo;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vecs [10];

    ble4_lut4_cfg_if #(.LUT_SIZE(4)) bus ();

    ble4_lut4_cfg dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.cfg_en    = 1'b1;
            bus.ccff_head = bits[i];
            tick();
        end
    endtask

    task automatic commit();
        bus.cfg_en    = 1'b0;
        bus.ccff_head = 1'b0;
        tick();
    endtask

    initial begin
        logic [24:0] pat;
        logic [31:0] fr;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.cfg_en    = 1'b0;
        bus.ccff_head = 1'b0;
        bus.lut_in    = 4'h0;

        //                 shift  frame      n   lin   v  e  o
        vecs[0] = '{1'b1, 18'h08000, 17, 4'hF, 1'b1, 1'b0, 1'b1}; // AND4
        vecs[1] = '{1'b0, 18'h00000,  0, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 18'h08001, 17, 4'hF, 1'b1, 1'b1, 1'b1}; // bad parity
        vecs[3] = '{1'b1, 18'h10000, 18, 4'hF, 1'b1, 1'b1, 1'b1}; // 18 bits
        vecs[4] = '{1'b1, 18'h07FFF, 16, 4'hF, 1'b1, 1'b1, 1'b1}; // 16 bits
        vecs[5] = '{1'b0, 18'h00000,  0, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 18'h16996, 17, 4'h1, 1'b1, 1'b0, 1'b1}; // XOR4
        vecs[7] = '{1'b0, 18'h00000,  0, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 18'h00000,  0, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 18'h00000,  0, 4'hF, 1'b1, 1'b0, 1'b0};

        #23;
        chk("rst_valid", bus.cfg_valid, 1'b0);
        chk("rst_err",   bus.cfg_err,   1'b0);
        chk("rst_tail",  bus.ccff_tail, 1'b0);
        chk("rst_out",   bus.lut_out,   1'b0);
        rst_n = 1'b1;
        tick();

        // A valid-looking table must not drive lut_out before any commit.
        bus.lut_in = 4'hF;
        #1;
        chk("idle_out", bus.lut_out, 1'b0);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].do_shift) begin
                fr = {14'd0, vecs[v].frame};
                shift_bits(fr, vecs[v].nbits);
                commit();
            end
            bus.lut_in = vecs[v].lin;
            #1;
            chk($sformatf("vec%0d_valid", v), bus.cfg_valid, vecs[v].ev);
            chk($sformatf("vec%0d_err",   v), bus.cfg_err,   vecs[v].ee);
            chk($sformatf("vec%0d_out",   v), bus.lut_out,   vecs[v].eo);
        end

        // Chain pass-through: tail repeats the head 17 edges later.
        pat = 25'b1_0110_1001_1100_0101_0011_1010;
        for (int k = 0; k < 25; k++) begin
            bus.cfg_en    = 1'b1;
            bus.ccff_head = pat[24-k];
            tick();
            if (k >= 16)
                chk($sformatf("tail_edge%0d", k + 1), bus.ccff_tail, pat[24-(k-16)]);
        end
        commit();
        chk("chain_err",   bus.cfg_err,   1'b1);
        chk("chain_valid", bus.cfg_valid, 1'b1);

        // Output gating around a reprogram with AND4.
        shift_bits(32'h08000, 17);
        commit();
        bus.lut_in = 4'hF;
        #1;
        chk("gate_pre", bus.lut_out, 1'b1);
        fr = 32'h08000;
        for (int i = 16; i >= 0; i--) begin
            bus.cfg_en    = 1'b1;
            bus.ccff_head = fr[i];
            #1;
            chk($sformatf("gate_bit%0d", i), bus.lut_out, 1'b0);
            tick();
        end
        bus.cfg_en    = 1'b0;
        bus.ccff_head = 1'b0;
        #1;
        chk("gate_commit_cycle", bus.lut_out, 1'b0);
        tick();
        chk("gate_after", bus.lut_out, 1'b1);
        chk("gate_err",   bus.cfg_err, 1'b0);

        // Reset in the middle of a shift.
        shift_bits(32'h16996 >> 9, 8);
        rst_n      = 1'b0;
        bus.cfg_en = 1'b0;
        #1;
        chk("mrst_valid", bus.cfg_valid, 1'b0);
        chk("mrst_err",   bus.cfg_err,   1'b0);
        chk("mrst_tail",  bus.ccff_tail, 1'b0);
        chk("mrst_out",   bus.lut_out,   1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        shift_bits(32'h16996, 17);
        commit();
        bus.lut_in = 4'h1;
        #1;
        chk("xor_valid", bus.cfg_valid, 1'b1);
        chk("xor_err",   bus.cfg_err,   1'b0);
        chk("xor_in1",   bus.lut_out,   1'b1);
        bus.lut_in = 4'h5;
        #1;
        chk("xor_in5",   bus.lut_out,   1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ble4_lut4_cfg.md
# ble4_lut4_cfg

Configurable 4-input LUT for the BLE4 datapath. It drives the `ff_D` input of the BLE flip-flop primitive. Its 16 truth-table bits arrive serially over the configuration-chain (ccff) fabric and are framed with an odd-parity bit. They are committed atomically to active memory only when a complete, error-free frame has been shifted. While the chain is shifting, and before the first valid commit, the LUT output is held low, so the downstream flip-flop never captures partially loaded logic.

## Interface
- `LUT_SIZE`, default 4: LUT input count. Truth table is 2**LUT_SIZE bits.
- `FRAME_W`, default 2**LUT_SIZE+1: shift-chain length (truth table plus parity bit).
- `clk  in  1`: global clock; the chain also shifts on this clock.
- `reset  in  1`: asynchronous, active-low reset.
- `cfg_en  in  1`: programming-mode enable; each high cycle shifts one bit.
- `ccff_head  in  1`: serial configuration input.
- `ccff_tail  out  1`: serial configuration output, `sr[FRAME_W-1]`; feeds the next tile's head.
- `lut_in  in  LUT_SIZE`: LUT select inputs; bit 0 is the LSB.
- `lut_out  out  1`: LUT result, connected to the flip-flop's `ff_D`.
- `cfg_valid  out  1`: active memory holds a committed, parity-checked configuration.
- `cfg_err  out  1`: the last frame was rejected (wrong length or bad parity); sticky until the next shift begins.

## Operation
- **Storage:**
  - Shift register `sr[FRAME_W-1:0]`.
  - Bit counter `cnt`, 5 bits, saturating at 31.
  - Active memory `mem[15:0]`.
  - State register.
- **States:**
  - IDLE: no valid configuration.
  - SHIFT.
  - ACTIVE: `cfg_valid`=1.
- **Shift:** on each edge with `cfg_en`=1, `sr <= {sr[FRAME_W-2:0], ccff_head}`.
- **Frame order:** parity bit first, then `mem[15]` down to `mem[0]`. After 17 shifts, `sr[16]` holds parity and `sr[15:0]` holds the truth table.
- **IDLE/ACTIVE → SHIFT:** on the first edge with `cfg_en`=1. That edge sets `cnt`=1, clears `cfg_err`, and performs the shift.
- **In SHIFT:** `cnt` increments per shifted bit and saturates at 31.
- **SHIFT → exit:** on the first edge with `cfg_en`=0 (commit edge).
  - Frame accepted when `cnt`==FRAME_W and XOR of `sr` is 1 (odd parity). Then `mem <= sr[15:0]`, `cfg_valid`=1, next state ACTIVE.
  - Otherwise: `cfg_err`=1, `mem` and `cfg_valid` unchanged, next state ACTIVE if `cfg_valid` else IDLE.
- **Output:** `lut_out = mem[lut_in]` when state==ACTIVE and `cfg_en`=0; otherwise 0. Combinational from `mem`, `lut_in` and `cfg_en`.
- **Chain output:** `ccff_tail` is registered (`sr` MSB) and passes through whatever is shifted, regardless of frame validity.

## Timing
- **Reset values:** `sr`=0, `cnt`=0, `mem`=0, state IDLE. Outputs: `cfg_valid`=0, `cfg_err`=0, `ccff_tail`=0, `lut_out`=0.
- **Reset mid-shift:** immediate return to the reset state. Any previous configuration is lost.
- **Chain latency:** one cycle per bit. `ccff_tail` equals the head bit shifted FRAME_W edges earlier.
- **Commit latency:**
  - `mem`/`cfg_valid`/`cfg_err` update on the commit edge.
  - `lut_out` reflects the new table in the cycle after the commit edge.
- **`cfg_en` deasserted for exactly one cycle:** a full commit edge occurs, and the following high edge starts a new frame with `cnt`=1.
- **`lut_out` gating:** `lut_out` is forced low combinationally in the same cycle `cfg_en` rises. No glitch reaches `ff_D` from a partial table.
- **`lut_in` changes:** change `lut_out` combinationally. There is no pipeline stage.

## Structure
- **Package `ble_cfg_pkg`:**
  - `LUT_SIZE` default.
  - `FRAME_W` function.
  - State enum `cfg_state_e` {IDLE, SHIFT, ACTIVE}.
  - Parity-sense constant (odd).
- **Sub-module `lut_cfg_chain`:** shift register, saturating counter and parity reduction. Outputs `sr`, `cnt` and `par_ok`.
- **Top level:** FSM, active memory and the output mux.

## Test plan
- **Program AND4:** reset, then shift parity 0 followed by 16'h8000 (17 cycles), drop `cfg_en` → `cfg_valid`=1, `cfg_err`=0. `lut_in`=4'hF → `lut_out`=1; `lut_in`=4'hE → `lut_out`=0.
- **Parity error:** after AND4, shift parity 0 followed by 16'h8001 → `cfg_err`=1, `cfg_valid`=1, `lut_in`=4'hF still gives 1 (old table retained).
- **Length error:** shift 18 bits (valid AND4 frame plus one extra 0) → `cfg_err`=1; with 16 bits → `cfg_err`=1; `mem` unchanged in both cases.
- **Chain pass-through:** shift 17 bits starting with 1 → `ccff_tail`=1 after the 17th edge; the next bits appear on `ccff_tail` in order, one per cycle.
- **Output gating:** in ACTIVE with `lut_in`=4'hF, raise `cfg_en` → `lut_out`=0 in the same cycle and stays 0 until one cycle after the commit edge.
- **Reset mid-shift:** assert `reset` low after 8 shifted bits → all outputs 0, state IDLE. The following valid XOR4 frame (parity 1, 16'h6996) commits, and `lut_in`=4'h1 → `lut_out`=1.
